fpu_fp32_to_fp64_seq: RTL and testbench

- Widens an IEEE-754 single (FP32) operand to a double (FP64) for the FPU register-file writeback and load-convert path.
- Pairs with the existing FP64-to-FP32 narrowing converter.
- Normals, zeros, infinities and NaNs convert in one cycle.
- Single-precision denormals are normalised by an iterative one-bit-per-cycle shifter, so the block uses a valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fp32_classify.sv | 18 +
 rtl/fpu_fp32_to_fp64_seq.sv | 92 +++++++++
 tb/tb_fpu_fp32_to_fp64_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32/FP64 field widths, exponent constants and FPU enums.
package fpu_pkg;
   localparam int F32_EXP_W  = 8;
   localparam int F32_FRAC_W = 23;
   localparam int F64_EXP_W  = 11;
   localparam int F64_FRAC_W = 52;
   localparam int BIAS32     = 127;
   localparam int BIAS64     = 1023;
   localparam int BIAS_DELTA = BIAS64 - BIAS32;
   // exponent of the smallest FP32 normal, re-biased for FP64
   localparam int DENORM_E0  = BIAS64 - BIAS32 + 1;
   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
   typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, QNAN, SNAN} fp_class_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: splits an FP32 operand into fields and its IEEE-754 class.
module fp32_classify
   import fpu_pkg::*;
(
   input  logic [31:0]           i_src,
   output fp_class_t             o_class,
   output logic                  o_sign,
   output logic [F32_EXP_W-1:0]  o_exp,
   output logic [F32_FRAC_W-1:0] o_frac
);
   assign o_sign = i_src[31];
   assign o_exp  = i_src[30:23];
   assign o_frac = i_src[22:0];
   always_comb
      o_class = o_exp == '0 ? (o_frac == '0 ? ZERO : DENORM)
              : o_exp == '1 ? (o_frac == '0 ? INF : o_frac[22] ? QNAN : SNAN)
              : NORMAL;
endmodule

// File: rtl/fpu_fp32_to_fp64_seq.sv
// fpu_fp32_to_fp64_seq: FP32-to-FP64 widening with valid/ready handshake;
// FP32 denormals are normalised one bit per cycle.
module fpu_fp32_to_fp64_seq
   import fpu_pkg::*;
#(
   parameter bit DENORM_EN = 1'b1,
   parameter bit NAN_QUIET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] src,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] dst,
   output logic        out_snan,
   output logic        out_denorm
);
   state_t                r_state, w_next;
   fp_class_t             w_class;
   logic                  w_sign, w_accept, w_norm_go, w_is_nan;
   logic [F32_EXP_W-1:0]  w_exp;
   logic [F32_FRAC_W-1:0] w_frac, w_nan_frac;
   logic [63:0]           w_fast_dst, r_dst;
   logic                  r_sign, r_snan, r_denorm;
   logic [F32_FRAC_W:0]   r_mant;
   logic [F64_EXP_W-1:0]  r_e;

   fp32_classify u_cls (
      .i_src  (src),
      .o_class(w_class),
      .o_sign (w_sign),
      .o_exp  (w_exp),
      .o_frac (w_frac)
   );

   assign w_accept   = in_valid && in_ready;
   assign w_norm_go  = DENORM_EN && w_class == DENORM;
   assign w_is_nan   = w_class == QNAN || w_class == SNAN;
   assign w_nan_frac = w_frac | {NAN_QUIET, 22'b0};

   // zero and flushed denormals both fall through to signed zero
   always_comb
      w_fast_dst = w_class == NORMAL ? {w_sign, {3'b0, w_exp} + 11'(BIAS_DELTA), w_frac, 29'b0}
                 : w_class == INF    ? {w_sign, 11'h7FF, 52'b0}
                 : w_is_nan          ? {w_sign, 11'h7FF, w_nan_frac, 29'b0}
                 : {w_sign, 63'b0};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   // an accept can only happen in IDLE or in DONE with out_ready
   always_comb
      w_next = w_accept              ? (w_norm_go ? NORM : DONE)
             : r_state == NORM       ? (r_mant[23] ? DONE : NORM)
             : r_state == DONE && out_ready ? IDLE
             : r_state;

   always_comb begin
      in_ready  = r_state == IDLE || (r_state == DONE && out_ready);
      out_valid = r_state == DONE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_dst    <= '0;
         r_sign   <= 1'b0;
         r_snan   <= 1'b0;
         r_denorm <= 1'b0;
         r_mant   <= '0;
         r_e      <= '0;
      end else if (w_accept) begin
         r_sign   <= w_sign;
         r_snan   <= w_class == SNAN;
         r_denorm <= w_class == DENORM;
         r_mant   <= {1'b0, w_frac};
         r_e      <= 11'(DENORM_E0);
         if (!w_norm_go) r_dst <= w_fast_dst;
      end else if (r_state == NORM) begin
         if (r_mant[23]) r_dst <= {r_sign, r_e, r_mant[22:0], 29'b0};
         else begin
            r_mant <= r_mant << 1;
            r_e    <= r_e - 11'd1;
         end
      end

   assign dst        = r_dst;
   assign out_snan   = r_snan;
   assign out_denorm = r_denorm;
endmodule

// File: tb/tb_fpu_fp32_to_fp64_seq.sv
// tb_fpu_fp32_to_fp64_seq: randomized scoreboard bench for the FP32-to-FP64 converter,
// with a real-arithmetic reference model and a second instance built with denormal flushing.
module tb_fpu_fp32_to_fp64_seq;
   typedef struct {
      logic [63:0] dst;
      logic        snan;
      logic        denorm;
      int          lat;
      int          acc;
   } exp_t;

   localparam bit NAN_QUIET = 1'b1;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] src = '0;
   logic        in_ready, out_valid, out_snan, out_denorm;
   logic [63:0] dst;
   logic        f_in_valid = 1'b0, f_out_ready = 1'b1;
   logic [31:0] f_src = '0;
   logic        f_in_ready, f_out_valid, f_out_snan, f_out_denorm;
   logic [63:0] f_dst;

   int   n_cmp = 0, n_fail = 0, cyc = 0;
   bit   rnd_bp = 1'b0, seen = 1'b0;
   exp_t q[$];
   exp_t m_e;
   logic m_rdy;

   fpu_fp32_to_fp64_seq #(.DENORM_EN(1'b1), .NAN_QUIET(NAN_QUIET)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .src(src),
      .out_valid(out_valid), .out_ready(out_ready), .dst(dst),
      .out_snan(out_snan), .out_denorm(out_denorm)
   );

   fpu_fp32_to_fp64_seq #(.DENORM_EN(1'b0), .NAN_QUIET(NAN_QUIET)) dut_f (
      .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready), .src(f_src),
      .out_valid(f_out_valid), .out_ready(f_out_ready), .dst(f_dst),
      .out_snan(f_out_snan), .out_denorm(f_out_denorm)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // value-level model: the FP64 result is the real number the FP32 encodes
   function automatic exp_t model(input logic [31:0] x, input bit den);
      exp_t        r;
      logic [7:0]  ex = x[30:23];
      logic [22:0] fr = x[22:0];
      int          m, msb;
      real         v;
      r.dst = '0; r.snan = 1'b0; r.denorm = 1'b0; r.lat = 1; r.acc = 0;
      if (ex == 8'hFF) begin
         r.dst = 64'h7FF0000000000000 | (64'(fr) << 29);
         if (fr != 0 && NAN_QUIET) r.dst[51] = 1'b1;
         r.snan = fr != 0 && !fr[22];
      end else if (ex == 0 && fr == 0) begin
         r.dst = '0;
      end else if (ex == 0 && !den) begin
         r.denorm = 1'b1;
      end else begin
         m = ex == 0 ? int'(fr) : int'(fr) + (1 << 23);
         v = real'(m) * (2.0 ** real'((ex == 0 ? 1 : int'(ex)) - 150));
         r.dst = $realtobits(v);
         if (ex == 0) begin
            r.denorm = 1'b1;
            msb = 0;
            for (int i = 0; i < 23; i++) if (fr[i]) msb = i;
            r.lat = (23 - msb) + 2;
         end
      end
      r.dst[63] = x[31];
      return r;
   endfunction

   function automatic logic [31:0] rand_src();
      logic        s = 1'($urandom_range(0, 1));
      int          c = $urandom_range(0, 5);
      logic [22:0] f = 23'($urandom);
      case (c)
         0: return {s, 8'($urandom_range(1, 254)), f};
         1: return {s, 31'b0};
         2: begin
            f = f >> $urandom_range(0, 22);
            if (f == 0) f = 23'd1;
            return {s, 8'h00, f};
         end
         3: return {s, 8'hFF, 23'b0};
         4: return {s, 8'hFF, (f == 0 ? 23'd1 : f)};
         default: return $urandom;
      endcase
   endfunction

   // monitor + scoreboard: checks before handling this cycle's accept
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         seen = 1'b0;
      end else begin
         m_rdy = out_valid ? out_ready : (q.size() == 0);
         chk("in_ready", {63'b0, in_ready}, {63'b0, m_rdy});
         if (out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
            else begin
               m_e = q[0];
               chk("dst", dst, m_e.dst);
               chk("flags", {62'b0, out_snan, out_denorm}, {62'b0, m_e.snan, m_e.denorm});
               if (!seen) begin
                  seen = 1'b1;
                  chk("latency", 64'(cyc - m_e.acc + 1), 64'(m_e.lat));
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end
         if (in_valid && in_ready) begin
            m_e = model(src, 1'b1);
            m_e.acc = cyc + 1;
            q.push_back(m_e);
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [31:0] x);
      int n = 0;
      bit acc = 1'b0;
      src = x;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   task automatic flush_case(input logic [31:0] x);
      exp_t r = model(x, 1'b0);
      f_src = x;
      f_in_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {63'b0, f_in_ready}, 64'd1);
      @(posedge clk);
      #1;
      f_in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {63'b0, f_out_valid}, 64'd1);
      chk("flush_dst", f_dst, r.dst);
      chk("flush_flags", {62'b0, f_out_snan, f_out_denorm}, {62'b0, r.snan, r.denorm});
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset_dst", dst, 64'd0);
      chk("reset_flags", {62'b0, out_snan, out_denorm}, 64'd0);
      chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h3F800000);
      drain();
      send(32'h80000000);
      send(32'h7F800000);
      send(32'h7F800001);
      send(32'h00000001);
      send(32'h00400000);
      drain();
      out_ready = 1'b0;
      send(32'h00400000);
      for (int n = 0; n < 40 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain();
      rnd_bp = 1'b1;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(rand_src());
      end
      drain();
      rnd_bp = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(32'h00000001);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
      chk("midreset_dst", dst, 64'd0);
      chk("midreset_in_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h40000000);
      drain();
      flush_case(32'h00000001);
      flush_case(32'h80000005);
      flush_case(32'h3F800000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
